// File: rtl/custom_cnt_sequencer_if.sv
// custom_cnt_sequencer_if
//   Groups the signals that pass between the count sequencer and the blocks
//   around it.
//   Request side (driven by the controller/consumer):
//     start, num_pass, abort, ready
//   Count side (driven by the sequencer):
//     cnt, cnt_valid, cnt_first, cnt_last, pass_idx, busy, done, aborted
//   The master modport is the controller/consumer side. The slave modport is
//   the sequencer side.
interface custom_cnt_sequencer_if #(
  parameter int CNT_W  = 5,
  parameter int PASS_W = 4
);
  logic              start;
  logic [PASS_W-1:0] num_pass;
  logic              abort;
  logic              ready;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_valid;
  logic              cnt_first;
  logic              cnt_last;
  logic [PASS_W-1:0] pass_idx;
  logic              busy;
  logic              done;
  logic              aborted;

  modport master (
    output start, num_pass, abort, ready,
    input  cnt, cnt_valid, cnt_first, cnt_last, pass_idx, busy, done, aborted
  );

  modport slave (
    input  start, num_pass, abort, ready,
    output cnt, cnt_valid, cnt_first, cnt_last, pass_idx, busy, done, aborted
  );
endinterface

// File: rtl/custom_cnt_sequencer.sv
// custom_cnt_sequencer
//   Generates the stage count 0..NUM_STEPS-1 for the address decoder. It
//   emits one count per accepted beat (cnt_valid & ready). The whole sequence
//   repeats for a programmable number of passes. A run is launched with
//   start and can be terminated with abort. The sequencer pulses done after
//   the final beat of the last pass is accepted.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    slave modport of custom_cnt_sequencer_if
//            inputs : start, num_pass, abort, ready
//            outputs: cnt, cnt_valid, cnt_first, cnt_last, pass_idx,
//                     busy, done, aborted (all registered)
module custom_cnt_sequencer #(
  parameter int CNT_W     = 5,
  parameter int NUM_STEPS = 25,
  parameter int PASS_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  custom_cnt_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_STEPS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
  logic [PASS_W-1:0] pass_tgt_q, pass_tgt_d;
  logic              cnt_valid_q, cnt_valid_d;
  logic              cnt_first_q, cnt_first_d;
  logic              cnt_last_q, cnt_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;
  logic              at_end;
  logic              last_pass;

  always_comb begin
    cnt_inc   = cnt_q + CNT_W'(1);
    accept    = cnt_valid_q & bus.ready;
    at_end    = (cnt_q == CNT_MAX);
    last_pass = (pass_idx_q == (pass_tgt_q - PASS_W'(1)));

    state_d     = state_q;
    cnt_d       = cnt_q;
    pass_idx_d  = pass_idx_q;
    pass_tgt_d  = pass_tgt_q;
    cnt_valid_d = cnt_valid_q;
    cnt_first_d = cnt_first_q;
    cnt_last_d  = cnt_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    case (state_q)
      // DONE accepts start exactly like IDLE, which allows back-to-back runs.
      // abort carries no meaning in either state.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          pass_tgt_d  = (bus.num_pass == '0) ? PASS_W'(1) : bus.num_pass;
          cnt_d       = '0;
          pass_idx_d  = '0;
          cnt_valid_d = 1'b1;
          cnt_first_d = 1'b1;
          cnt_last_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_RUN;
        end else begin
          cnt_valid_d = 1'b0;
          cnt_first_d = 1'b0;
          cnt_last_d  = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          // abort takes priority over a beat accepted in the same cycle.
          cnt_d       = '0;
          pass_idx_d  = '0;
          cnt_valid_d = 1'b0;
          cnt_first_d = 1'b0;
          cnt_last_d  = 1'b0;
          busy_d      = 1'b0;
          aborted_d   = 1'b1;
          state_d     = S_IDLE;
        end else if (accept) begin
          if (!at_end) begin
            cnt_d       = cnt_inc;
            cnt_first_d = 1'b0;
            cnt_last_d  = (cnt_inc == CNT_MAX);
          end else if (!last_pass) begin
            // A new pass starts on the next cycle with no idle cycle between passes.
            cnt_d       = '0;
            pass_idx_d  = pass_idx_q + PASS_W'(1);
            cnt_first_d = 1'b1;
            cnt_last_d  = 1'b0;
          end else begin
            cnt_valid_d = 1'b0;
            cnt_first_d = 1'b0;
            cnt_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      default: begin
        cnt_d       = '0;
        pass_idx_d  = '0;
        cnt_valid_d = 1'b0;
        cnt_first_d = 1'b0;
        cnt_last_d  = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pass_idx_q  <= '0;
      pass_tgt_q  <= '0;
      cnt_valid_q <= 1'b0;
      cnt_first_q <= 1'b0;
      cnt_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pass_idx_q  <= pass_idx_d;
      pass_tgt_q  <= pass_tgt_d;
      cnt_valid_q <= cnt_valid_d;
      cnt_first_q <= cnt_first_d;
      cnt_last_q  <= cnt_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.cnt_first = cnt_first_q;
  assign bus.cnt_last  = cnt_last_q;
  assign bus.pass_idx  = pass_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_custom_cnt_sequencer.sv
// tb_custom_cnt_sequencer
//   Self-checking bench for custom_cnt_sequencer. The expected beat stream of
//   a run is built up front as a queue of (pass, cnt) pairs. The DUT output
//   is compared with the queue head each cycle, and the head is popped on
//   every accepted beat.
module tb_custom_cnt_sequencer;

  localparam int CW = 5;
  localparam int NS = 25;
  localparam int PW = 4;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  custom_cnt_sequencer_if #(.CNT_W(CW), .PASS_W(PW)) bus ();

  custom_cnt_sequencer #(.CNT_W(CW), .NUM_STEPS(NS), .PASS_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish, got no end, need end");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       start;
    logic [3:0] np;
    logic       abort;
    logic       ready;
    int v; int c; int p; int b; int d; int a; int f; int l;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d need %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int c, input int p,
                         input int b, input int d, input int a, input int f, input int l);
    chk({tag, ".cnt_valid"}, int'(bus.cnt_valid), v);
    chk({tag, ".cnt"},       int'(bus.cnt),       c);
    chk({tag, ".pass_idx"},  int'(bus.pass_idx),  p);
    chk({tag, ".busy"},      int'(bus.busy),      b);
    chk({tag, ".done"},      int'(bus.done),      d);
    chk({tag, ".aborted"},   int'(bus.aborted),   a);
    chk({tag, ".cnt_first"}, int'(bus.cnt_first), f);
    chk({tag, ".cnt_last"},  int'(bus.cnt_last),  l);
  endtask

  // Runs one sequence from IDLE or from a DONE cycle. It checks each cycle
  // against the expected beat queue. abort_beat >= 0 asserts abort once that
  // many beats have been accepted. With chain=1 the task returns in the DONE
  // cycle with start driven high.
  task automatic run_seq(input int np, input int rdy_pct, input int abort_beat, input bit chain);
    int q_cnt[$];
    int q_pass[$];
    int tgt;
    int accepted;
    int guard;
    bit ab_now;
    bit rd_now;
    tgt = (np == 0) ? 1 : np;
    for (int p = 0; p < tgt; p++)
      for (int c = 0; c < NS; c++) begin
        q_cnt.push_back(c);
        q_pass.push_back(p);
      end
    bus.start    = 1'b1;
    bus.num_pass = PW'(np);
    bus.abort    = 1'b0;
    bus.ready    = 1'b0;
    step();
    accepted = 0;
    guard    = 0;
    while (q_cnt.size() > 0 && guard < 5000) begin
      guard++;
      chk_out("run", 1, q_cnt[0], q_pass[0], 1, 0, 0,
              int'(q_cnt[0] == 0), int'(q_cnt[0] == NS - 1));
      rd_now       = ($urandom_range(0, 99) < rdy_pct);
      ab_now       = (abort_beat >= 0) && (accepted == abort_beat);
      bus.ready    = rd_now;
      bus.abort    = ab_now;
      bus.start    = 1'($urandom_range(0, 1));
      bus.num_pass = PW'($urandom);
      step();
      if (ab_now) begin
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk_out("abort", 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        chk_out("post_abort", 0, 0, 0, 0, 0, 0, 0, 0);
        return;
      end
      if (rd_now) begin
        void'(q_cnt.pop_front());
        void'(q_pass.pop_front());
        accepted++;
      end
    end
    chk("run.no_timeout", int'(guard < 5000), 1);
    chk("run.beats", accepted, tgt * NS);
    chk("done.done",      int'(bus.done),      1);
    chk("done.cnt_valid", int'(bus.cnt_valid), 0);
    chk("done.busy",      int'(bus.busy),      0);
    chk("done.aborted",   int'(bus.aborted),   0);
    bus.abort = 1'($urandom_range(0, 1));
    if (chain) begin
      bus.start = 1'b1;
      return;
    end
    bus.start = 1'b0;
    step();
    bus.abort = 1'b0;
    chk("idle.done",      int'(bus.done),      0);
    chk("idle.cnt_valid", int'(bus.cnt_valid), 0);
    chk("idle.busy",      int'(bus.busy),      0);
  endtask

  vec_t tbl[11];

  initial begin
    int np;
    int tgt;
    int ab;
    bit chain;
    total = 0;
    bad   = 0;

    // Each row gives the inputs driven before an edge and the outputs
    // expected after that edge.
    //            start np     abort ready  v  c  p  b  d  a  f  l
    tbl[0]  = '{1'b0, 4'd0, 1'b0, 1'b0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 4'd0, 1'b0, 1'b0,  1, 0, 0, 1, 0, 0, 1, 0};
    tbl[2]  = '{1'b0, 4'd0, 1'b0, 1'b0,  1, 0, 0, 1, 0, 0, 1, 0};
    tbl[3]  = '{1'b1, 4'd5, 1'b0, 1'b0,  1, 0, 0, 1, 0, 0, 1, 0};
    tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b1,  1, 1, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 4'd0, 1'b0, 1'b1,  1, 2, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{1'b0, 4'd0, 1'b1, 1'b0,  0, 0, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1'b1, 4'd2, 1'b0, 1'b1,  1, 0, 0, 1, 0, 0, 1, 0};
    tbl[9]  = '{1'b0, 4'd0, 1'b1, 1'b1,  0, 0, 0, 0, 0, 1, 0, 0};
    tbl[10] = '{1'b0, 4'd0, 1'b1, 1'b0,  0, 0, 0, 0, 0, 0, 0, 0};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.num_pass = '0;
    bus.abort    = 1'b0;
    bus.ready    = 1'b0;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_out("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      bus.start    = tbl[i].start;
      bus.num_pass = tbl[i].np;
      bus.abort    = tbl[i].abort;
      bus.ready    = tbl[i].ready;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].c, tbl[i].p, tbl[i].b,
              tbl[i].d, tbl[i].a, tbl[i].f, tbl[i].l);
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;

    // single pass, ready held high
    run_seq(1, 100, -1, 1'b0);
    // three passes, then a restart issued in the DONE cycle with num_pass=0
    run_seq(3, 100, -1, 1'b1);
    run_seq(0, 100, -1, 1'b0);
    // ready toggling
    run_seq(1, 50, -1, 1'b0);
    // abort at pass 1, cnt 12 with ready high, then a fresh run
    run_seq(3, 100, NS + 12, 1'b0);
    run_seq(2, 100, -1, 1'b0);

    // reset pulled low mid-run at cnt=5
    bus.start    = 1'b1;
    bus.num_pass = 4'd2;
    bus.ready    = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    chk("pre_rst.cnt", int'(bus.cnt), 5);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk_out("after_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    bus.ready = 1'b0;

    // randomized runs
    for (int k = 0; k < 10; k++) begin
      np    = $urandom_range(0, 4);
      tgt   = (np == 0) ? 1 : np;
      ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tgt * NS - 1)) : -1;
      chain = (k == 9) ? 1'b0 : 1'($urandom_range(0, 1));
      if (ab >= 0) chain = 1'b0;
      run_seq(np, $urandom_range(30, 100), ab, chain);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
